fc_layer: RTL and testbench
===========================

FC_LAYER -- requirements
Module: fc_layer

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  N_IN, 2048, inputs per neuron (flattened layer-2 length)
  N_OUT, 10, output neurons
  DW, 20, data width, signed Q4.16
  FRAC, 16, fractional bits
REQ-002 Ports (name, direction, width, meaning), one per line:
  clk  in  1  sole clock, rising edge
  reset  in  1  synchronous, active-high
  start  in  1  single-cycle pulse that begins one full pass
  busy  out  1  high from the cycle after accepted start until done
  done  out  1  one-cycle pulse after the last result write
  xrd  out  1  flattened-input read strobe
  xaddr  out  11  flattened-input address i
  xdata  in  20  flattened-input data, valid 1 cycle after xrd/xaddr
  wrd  out  1  weight read strobe
  waddr  out  15  weight address o*N_IN+i
  wdata  in  20  weight data, valid 1 cycle after wrd/waddr
  baddr  out  4  bias address o
  bdata  in  20  bias data, valid 1 cycle after baddr
  rwr  out  1  result write strobe
  raddr  out  4  result address o
  rdata  out  20  result data, signed Q4.16
REQ-003 Clocking and reset: one clock; reset is synchronous and active-high.

Function
REQ-004 States: IDLE, BIAS, MAC, DRAIN, WRITE, FIN.
REQ-005 Transitions: IDLE->BIAS on start; BIAS->MAC after 1 cycle; MAC->DRAIN after N_IN cycles; DRAIN->WRITE after 2 cycles; WRITE->BIAS if o<N_OUT-1, else WRITE->FIN; FIN->IDLE after 1 cycle.
REQ-006 BIAS: drives baddr=o, clears accumulator, and latches bdata on the following cycle.
REQ-007 MAC: xrd=wrd=1 and i steps 0..N_IN-1 with one address per cycle; xaddr=i, waddr=o*N_IN+i.
REQ-008 Pipeline: read data registered at t+1, product registered at t+2, accumulated at t+3; DRAIN flushes the last two products.
REQ-009 Arithmetic: 40-bit signed product; 52-bit signed accumulator with no overflow possible.
REQ-010 Round and bias: y = (acc + 2^15) >>> 16 (arithmetic shift), then add sign-extended bias.
REQ-011 Saturation: y > 0x7FFFF gives 0x7FFFF; y < -0x80000 gives 0x80000.
REQ-012 WRITE: rwr=1 for exactly one cycle with raddr=o and rdata=the saturated y. No ReLU is applied.
REQ-013 Per-neuron latency is 1+N_IN+2+1 = 2052 cycles. Full pass is N_OUT*2052+1 cycles from start to done.
REQ-014 done is high in the FIN cycle; busy falls in the same cycle.
REQ-015 start while busy is ignored; no restart.
REQ-016 xrd and wrd are 0 outside MAC; rwr is 0 outside WRITE.
REQ-017 Addresses hold their last value when not in use.
REQ-018 Neuron index o runs from 0 to N_OUT-1, with no wrap-around within a pass.

Reset
REQ-019 Reset returns the block to IDLE with busy=done=xrd=wrd=rwr=0 and every address, rdata, the accumulator and the pipeline registers at 0.
REQ-020 Reset asserted mid-pass aborts that pass: no further rwr pulse is issued and no done pulse is issued.
REQ-021 After reset deasserts, the block accepts a new start.

Structure
REQ-022 Shared package (fc_pkg) holds the state enum, DW, FRAC, ACC_W=52, SAT_MAX=20'h7FFFF and SAT_MIN=20'h80000.
REQ-023 One sub-module, fc_mac, holds the product register, the accumulator, round/bias/saturate, and a clear/enable control.
REQ-024 The FSM and address counters live in fc_layer.

Verification
REQ-025 All x=0 and every bias=0x01310 -> ten writes, raddr 0..9, each rdata=0x01310, then done.
REQ-026 x[0]=0x10000, all other x=0, w[o][0]=0x08000, bias=0 -> every rdata=0x08000.
REQ-027 All x=0x10000, all w=0x10000, bias=0 (sum 2048.0) -> every rdata=0x7FFFF; with w=0xF0000 -> every rdata=0x80000.
REQ-028 Rounding: x[0]=0x00001, w[o][0]=0x08000, rest 0, bias 0 -> rdata=0x00001; with w[o][0]=0x07FFF -> rdata=0x00000.
REQ-029 Reset pulsed during MAC of neuron 3 -> no rwr for raddr>=3 and no done; a new start then completes all ten writes with correct values.
REQ-030 start re-pulsed at cycle 100 of a pass -> ignored; done arrives exactly N_OUT*2052+1 cycles after the first start.

Source files
------------

// File: rtl/fc_pkg.sv
// ============================================================================
// Module   : fc_pkg
// Purpose  : Shared types and constants for the fully-connected layer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fc_pkg;

    localparam int DW    = 20;
    localparam int FRAC  = 16;
    localparam int ACC_W = 52;

    localparam logic [DW-1:0] SAT_MAX = 20'h7FFFF;
    localparam logic [DW-1:0] SAT_MIN = 20'h80000;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_BIAS  = 3'd1,
        S_MAC   = 3'd2,
        S_DRAIN = 3'd3,
        S_WRITE = 3'd4,
        S_FIN   = 3'd5
    } state_t;

endpackage

`default_nettype wire

// File: rtl/fc_mac.sv
// ============================================================================
// Module   : fc_mac
// Purpose  : Product register, accumulator, bias latch, round and saturate.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fc_mac #(
    parameter int DW   = fc_pkg::DW,
    parameter int FRAC = fc_pkg::FRAC
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_clear,
    input  logic                 i_en,
    input  logic signed [DW-1:0] i_x,
    input  logic signed [DW-1:0] i_w,
    input  logic signed [DW-1:0] i_b,
    output logic        [DW-1:0] o_y
);
    import fc_pkg::*;

    localparam int PW = 2 * DW;
    localparam logic signed [ACC_W-1:0] c_half = {{(ACC_W-1){1'b0}}, 1'b1} << (FRAC - 1);
    localparam logic signed [ACC_W-1:0] c_max  = {{(ACC_W-DW){SAT_MAX[DW-1]}}, SAT_MAX};
    localparam logic signed [ACC_W-1:0] c_min  = {{(ACC_W-DW){SAT_MIN[DW-1]}}, SAT_MIN};

    logic                    r_v1;
    logic                    r_v2;
    logic                    r_bld;
    logic signed [PW-1:0]    r_prod;
    logic signed [ACC_W-1:0] r_acc;
    logic signed [DW-1:0]    r_bias;
    logic signed [ACC_W-1:0] w_y;

    // Read data arrives one cycle after the address strobe, so the valid
    // bits trail i_en by one (product) and two (accumulate) cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1   <= 1'b0;
            r_v2   <= 1'b0;
            r_bld  <= 1'b0;
            r_prod <= '0;
            r_acc  <= '0;
            r_bias <= '0;
        end else begin
            r_v1  <= i_en;
            r_v2  <= r_v1;
            r_bld <= i_clear;
            if (r_v1)
                r_prod <= PW'(i_x) * PW'(i_w);
            if (r_bld)
                r_bias <= i_b;
            if (i_clear)
                r_acc <= '0;
            else if (r_v2)
                r_acc <= r_acc + ACC_W'(r_prod);
        end
    end

    assign w_y = ((r_acc + c_half) >>> FRAC) + ACC_W'(r_bias);

    always_comb begin
        o_y = w_y[DW-1:0];
        if (w_y > c_max)
            o_y = SAT_MAX;
        else if (w_y < c_min)
            o_y = SAT_MIN;
    end

endmodule

`default_nettype wire

// File: rtl/fc_layer.sv
// ============================================================================
// Module   : fc_layer
// Purpose  : Sequential fully-connected layer, one MAC per cycle per neuron.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fc_layer #(
    parameter  int N_IN  = 2048,
    parameter  int N_OUT = 10,
    parameter  int DW    = fc_pkg::DW,
    parameter  int FRAC  = fc_pkg::FRAC,
    localparam int XA_W  = $clog2(N_IN),
    localparam int WA_W  = $clog2(N_IN * N_OUT),
    localparam int OA_W  = $clog2(N_OUT)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic            xrd,
    output logic [XA_W-1:0] xaddr,
    input  logic [DW-1:0]   xdata,
    output logic            wrd,
    output logic [WA_W-1:0] waddr,
    input  logic [DW-1:0]   wdata,
    output logic [OA_W-1:0] baddr,
    input  logic [DW-1:0]   bdata,
    output logic            rwr,
    output logic [OA_W-1:0] raddr,
    output logic [DW-1:0]   rdata
);
    import fc_pkg::*;

    state_t          r_state;
    state_t          w_next;
    logic [XA_W-1:0] r_i;
    logic [WA_W-1:0] r_waddr;
    logic [OA_W-1:0] r_o;
    logic            r_dcnt;
    logic [DW-1:0]   r_rdata;
    logic [DW-1:0]   w_y;
    logic            w_last_i;
    logic            w_last_o;

    assign w_last_i = (r_i == XA_W'(N_IN - 1));
    assign w_last_o = (r_o == OA_W'(N_OUT - 1));

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_BIAS;
            S_BIAS:  w_next = S_MAC;
            S_MAC:   if (w_last_i) w_next = S_DRAIN;
            S_DRAIN: if (r_dcnt) w_next = S_WRITE;
            S_WRITE: w_next = w_last_o ? S_FIN : S_BIAS;
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Address registers only move while in use so they hold between neurons.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_i     <= '0;
            r_waddr <= '0;
            r_o     <= '0;
            r_dcnt  <= 1'b0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start)
                        r_o <= '0;
                end
                S_BIAS: begin
                    r_i     <= '0;
                    r_waddr <= WA_W'(r_o) * WA_W'(N_IN);
                    r_dcnt  <= 1'b0;
                end
                S_MAC: begin
                    if (!w_last_i) begin
                        r_i     <= r_i + 1'b1;
                        r_waddr <= r_waddr + 1'b1;
                    end
                end
                S_DRAIN: begin
                    r_dcnt <= 1'b1;
                end
                S_WRITE: begin
                    r_rdata <= w_y;
                    if (!w_last_o)
                        r_o <= r_o + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    fc_mac #(
        .DW   (DW),
        .FRAC (FRAC)
    ) u_mac (
        .clk     (clk),
        .rst     (reset),
        .i_clear (r_state == S_BIAS),
        .i_en    (r_state == S_MAC),
        .i_x     (xdata),
        .i_w     (wdata),
        .i_b     (bdata),
        .o_y     (w_y)
    );

    assign busy  = (r_state != S_IDLE) && (r_state != S_FIN);
    assign done  = (r_state == S_FIN);
    assign xrd   = (r_state == S_MAC);
    assign wrd   = (r_state == S_MAC);
    assign rwr   = (r_state == S_WRITE);
    assign xaddr = r_i;
    assign waddr = r_waddr;
    assign baddr = r_o;
    assign raddr = r_o;
    assign rdata = rwr ? w_y : r_rdata;

endmodule

`default_nettype wire

// File: tb/tb_fc_layer.sv
// ============================================================================
// Module   : tb_fc_layer
// Purpose  : Self-checking bench for fc_layer against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fc_layer;

    localparam int N_IN   = 64;
    localparam int N_OUT  = 10;
    localparam int DW     = 20;
    localparam int FRAC   = 16;
    localparam int XA_W   = $clog2(N_IN);
    localparam int WA_W   = $clog2(N_IN * N_OUT);
    localparam int OA_W   = $clog2(N_OUT);
    localparam int NEURON = 1 + N_IN + 2 + 1;
    localparam int PASS   = N_OUT * NEURON + 1;

    logic            clk   = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic            busy, done, xrd, wrd, rwr;
    logic [XA_W-1:0] xaddr;
    logic [WA_W-1:0] waddr;
    logic [OA_W-1:0] baddr, raddr;
    logic [DW-1:0]   xdata = '0, wdata = '0, bdata = '0;
    logic [DW-1:0]   rdata;

    fc_layer #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(DW), .FRAC(FRAC)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .xrd(xrd), .xaddr(xaddr), .xdata(xdata),
        .wrd(wrd), .waddr(waddr), .wdata(wdata),
        .baddr(baddr), .bdata(bdata),
        .rwr(rwr), .raddr(raddr), .rdata(rdata)
    );

    always #5 clk = ~clk;

    // Synchronous-read memories feeding the DUT
    logic [DW-1:0] xm [N_IN];
    logic [DW-1:0] wm [N_IN*N_OUT];
    logic [DW-1:0] bm [N_OUT];

    always @(posedge clk) begin
        if (xrd) xdata <= xm[xaddr];
        if (wrd) wdata <= wm[waddr];
        bdata <= bm[baddr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int            errors = 0;
    int            checks = 0;
    logic [OA_W-1:0] wa [$];
    logic [DW-1:0]   wd [$];
    int            n_done = 0;
    int            done_cyc = 0;
    logic          busy_at_done = 1'b0;

    always @(posedge clk) begin
        #1;
        if (rwr) begin
            wa.push_back(raddr);
            wd.push_back(rdata);
        end
        if (done) begin
            n_done++;
            done_cyc = cyc;
            busy_at_done = busy;
        end
    end

    function automatic logic [DW-1:0] ref_y(input int o);
        longint acc, y;
        acc = 0;
        for (int i = 0; i < N_IN; i++)
            acc += longint'($signed(xm[i])) * longint'($signed(wm[o*N_IN+i]));
        y = (acc + 32768) >>> FRAC;
        y = y + longint'($signed(bm[o]));
        if (y > 524287)       y = 524287;
        else if (y < -524288) y = -524288;
        return y[DW-1:0];
    endfunction

    task automatic fill_random(input bit bounded);
        for (int i = 0; i < N_IN; i++)
            xm[i] = bounded ? 20'($urandom_range(0, 8191)) - 20'd4096 : 20'($urandom());
        for (int i = 0; i < N_IN*N_OUT; i++)
            wm[i] = bounded ? 20'($urandom_range(0, 131071)) - 20'd65536 : 20'($urandom());
        for (int o = 0; o < N_OUT; o++)
            bm[o] = bounded ? 20'($urandom_range(0, 65535)) - 20'd32768 : 20'($urandom());
    endtask

    task automatic run_pass(input int repulse_at, output bit to, output int st_cyc,
                            output logic busy_after);
        wa.delete();
        wd.delete();
        n_done = 0;
        @(negedge clk);
        start  = 1'b1;
        st_cyc = cyc;
        @(negedge clk);
        start      = 1'b0;
        busy_after = busy;
        to = 1'b1;
        for (int k = 1; k < PASS + 20; k++) begin
            if (n_done > 0) begin
                to = 1'b0;
                break;
            end
            start = (repulse_at > 0) && (k == repulse_at);
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, xrd, wrd, rwr} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 00000", {busy, done, xrd, wrd, rwr});
        end
        checks++;
        if ({xaddr, waddr, baddr, raddr} !== '0) begin
            errors++;
            $display("FAIL reset_addr: got %h expected 0", {xaddr, waddr, baddr, raddr});
        end
        checks++;
        if (rdata !== '0) begin
            errors++;
            $display("FAIL reset_rdata: got %h expected 0", rdata);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_busy: got %b expected 0", busy);
        end
    endtask

    task automatic test_directed(input string name, input logic [DW-1:0] x0, xr, w0, wr, b,
                                 exp_y);
        bit   to;
        int   st;
        logic ba;
        for (int i = 0; i < N_IN; i++) xm[i] = (i == 0) ? x0 : xr;
        for (int o = 0; o < N_OUT; o++) begin
            bm[o] = b;
            for (int i = 0; i < N_IN; i++) wm[o*N_IN+i] = (i == 0) ? w0 : wr;
        end
        run_pass(0, to, st, ba);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL %s_timeout: no done within %0d cycles", name, PASS + 20);
        end
        checks++;
        if (wa.size() != N_OUT) begin
            errors++;
            $display("FAIL %s_nwrites: got %0d expected %0d", name, wa.size(), N_OUT);
        end
        for (int o = 0; o < wa.size(); o++) begin
            checks++;
            if (wa[o] !== OA_W'(o) || wd[o] !== exp_y) begin
                errors++;
                $display("FAIL %s_write%0d: got addr %0d data %h expected addr %0d data %h",
                         name, o, wa[o], wd[o], o, exp_y);
            end
        end
        checks++;
        if (done_cyc - st != PASS) begin
            errors++;
            $display("FAIL %s_latency: got %0d expected %0d", name, done_cyc - st, PASS);
        end
        checks++;
        if (ba !== 1'b1 || busy_at_done !== 1'b0) begin
            errors++;
            $display("FAIL %s_busy: got start %b done %b expected 1 0", name, ba, busy_at_done);
        end
    endtask

    task automatic test_random(input bit bounded);
        bit   to;
        int   st;
        logic ba;
        logic [DW-1:0] e;
        fill_random(bounded);
        run_pass(0, to, st, ba);
        checks++;
        if (to || wa.size() != N_OUT) begin
            errors++;
            $display("FAIL random_pass: got timeout %0d writes %0d expected 0 %0d",
                     to, wa.size(), N_OUT);
        end
        for (int o = 0; o < wa.size(); o++) begin
            e = ref_y(o);
            checks++;
            if (wa[o] !== OA_W'(o) || wd[o] !== e) begin
                errors++;
                $display("FAIL random_write%0d: got addr %0d data %h expected addr %0d data %h",
                         o, wa[o], wd[o], o, e);
            end
        end
    endtask

    task automatic test_reset_midpass;
        bit   to;
        int   st;
        logic ba;
        fill_random(1'b1);
        wa.delete();
        wd.delete();
        n_done = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3*NEURON + 10) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2*NEURON) @(negedge clk);
        checks++;
        if (wa.size() != 3 || n_done != 0) begin
            errors++;
            $display("FAIL abort_writes: got %0d writes %0d dones expected 3 0",
                     wa.size(), n_done);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_busy: got %b expected 0", busy);
        end
        run_pass(0, to, st, ba);
        checks++;
        if (to || wa.size() != N_OUT || done_cyc - st != PASS) begin
            errors++;
            $display("FAIL restart_pass: got timeout %0d writes %0d latency %0d expected 0 %0d %0d",
                     to, wa.size(), done_cyc - st, N_OUT, PASS);
        end
        for (int o = 0; o < wa.size(); o++) begin
            checks++;
            if (wa[o] !== OA_W'(o) || wd[o] !== ref_y(o)) begin
                errors++;
                $display("FAIL restart_write%0d: got addr %0d data %h expected addr %0d data %h",
                         o, wa[o], wd[o], o, ref_y(o));
            end
        end
    endtask

    task automatic test_start_ignored;
        bit   to;
        int   st;
        logic ba;
        fill_random(1'b1);
        run_pass(100, to, st, ba);
        checks++;
        if (to || done_cyc - st != PASS) begin
            errors++;
            $display("FAIL restart_ignored_latency: got timeout %0d latency %0d expected 0 %0d",
                     to, done_cyc - st, PASS);
        end
        checks++;
        if (wa.size() != N_OUT || n_done != 1) begin
            errors++;
            $display("FAIL restart_ignored_count: got %0d writes %0d dones expected %0d 1",
                     wa.size(), n_done, N_OUT);
        end
        repeat (NEURON) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || n_done != 1) begin
            errors++;
            $display("FAIL restart_ignored_idle: got busy %b dones %0d expected 0 1", busy, n_done);
        end
    endtask

    initial begin
        test_reset();
        test_directed("bias_only", 20'h0, 20'h0, 20'h12345, 20'h3ABCD, 20'h01310, 20'h01310);
        test_directed("neg_bias",  20'h0, 20'h0, 20'h12345, 20'h3ABCD, 20'hFFFF0, 20'hFFFF0);
        test_directed("one_tap",   20'h10000, 20'h0, 20'h08000, 20'h3ABCD, 20'h0, 20'h08000);
        test_directed("sat_pos",   20'h10000, 20'h10000, 20'h10000, 20'h10000, 20'h0, 20'h7FFFF);
        test_directed("sat_neg",   20'h10000, 20'h10000, 20'hF0000, 20'hF0000, 20'h0, 20'h80000);
        test_directed("round_up",  20'h00001, 20'h0, 20'h08000, 20'h0, 20'h0, 20'h00001);
        test_directed("round_dn",  20'h00001, 20'h0, 20'h07FFF, 20'h0, 20'h0, 20'h00000);
        test_directed("round_neg", 20'hFFFFF, 20'h0, 20'h08001, 20'h0, 20'h0, 20'hFFFFF);
        test_reset_midpass();
        test_start_ignored();
        test_random(1'b1);
        test_random(1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
